// File: rtl/apu_frame_tx_if.sv
// Register-write request channel into apu_frame_tx.
// Plain valid/ready handshake carrying one APU register write.
interface apu_frame_tx_if;
   logic       wr_valid;
   logic [4:0] wr_addr;
   logic [7:0] wr_data;
   logic       wr_ready;

   modport master (
      output wr_valid,
      output wr_addr,
      output wr_data,
      input  wr_ready
   );

   modport slave (
      input  wr_valid,
      input  wr_addr,
      input  wr_data,
      output wr_ready
   );
endinterface

// File: rtl/apu_frame_tx.sv
// Serial frame transmitter: queues APU register writes and sends each one
// as two back-to-back 8N1 bytes, {3'b100, addr} then data.
module apu_frame_tx #(
   parameter int unsigned CLKRATE  = 2_000_000,
   parameter int unsigned BAUDRATE = 9600,
   parameter int unsigned DEPTH    = 4
) (
   input  logic           clk,
   input  logic           reset_n,
   apu_frame_tx_if.slave  wr,
   output logic           busy,
   output logic           tx
);

   localparam int unsigned DIV = CLKRATE / BAUDRATE;
   localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned AW  = $clog2(DEPTH);

   localparam logic [CW-1:0] BIT_END = CW'(DIV - 1);
   localparam logic [AW:0]   FULL    = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_e;

   state_e        state_q, state_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic          byte_sel_q, byte_sel_d;
   logic [7:0]    shifter_q, shifter_d;
   logic [7:0]    hold_q, hold_d;
   logic [CW-1:0] baud_q, baud_d;
   logic          tx_q, tx_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [12:0]   mem_q [DEPTH];

   logic        push;
   logic        pop;
   logic        bit_end;
   logic [12:0] head;

   assign wr.wr_ready = (cnt_q != FULL);
   assign push        = wr.wr_valid && wr.wr_ready;
   assign head        = mem_q[rd_ptr_q];
   assign bit_end     = (baud_q == BIT_END);
   assign busy        = (state_q != IDLE) || (cnt_q != '0);
   assign tx          = tx_q;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {wr.wr_addr, wr.wr_data};
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_idx_d  = bit_idx_q;
      byte_sel_d = byte_sel_q;
      shifter_d  = shifter_q;
      hold_d     = hold_q;
      baud_d     = baud_q + 1'b1;
      pop        = 1'b0;
      tx_d       = 1'b1;

      unique case (state_q)
         IDLE: begin
            baud_d = '0;
            if (cnt_q != '0) begin
               pop = 1'b1;
            end
         end
         START: begin
            if (bit_end) begin
               state_d   = DATA;
               bit_idx_d = 3'd0;
               baud_d    = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_d = '0;
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  shifter_d = shifter_q >> 1;
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               baud_d = '0;
               if (!byte_sel_q) begin
                  shifter_d  = hold_q;
                  byte_sel_d = 1'b1;
                  state_d    = START;
               end else if (cnt_q != '0) begin
                  pop = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            baud_d  = '0;
         end
      endcase

      // Second byte is held aside because the slot may be refilled once popped.
      if (pop) begin
         shifter_d  = {3'b100, head[12:8]};
         hold_d     = head[7:0];
         byte_sel_d = 1'b0;
         state_d    = START;
         baud_d     = '0;
      end

      // tx is registered from next state so it changes on the entry edge.
      unique case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shifter_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         bit_idx_q  <= '0;
         byte_sel_q <= 1'b0;
         shifter_q  <= '0;
         hold_q     <= '0;
         baud_q     <= '0;
         tx_q       <= 1'b1;
         cnt_q      <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         bit_idx_q  <= bit_idx_d;
         byte_sel_q <= byte_sel_d;
         shifter_q  <= shifter_d;
         hold_q     <= hold_d;
         baud_q     <= baud_d;
         tx_q       <= tx_d;
         cnt_q      <= cnt_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

endmodule

// File: tb/tb_apu_frame_tx.sv
// Directed bench for apu_frame_tx with a mid-bit sampling UART decoder.
// Baud chosen so the divisor truncates: 2_000_000 / 120_000 -> 16.
module tb_apu_frame_tx;

   localparam int unsigned CLK  = 2_000_000;
   localparam int unsigned BAUD = 120_000;
   localparam int          D    = 16;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic busy;
   logic tx;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   int acc, t0, ts_r, prev_r, lows, wi, g;

   apu_frame_tx_if wr ();

   apu_frame_tx #(
      .CLKRATE (CLK),
      .BAUDRATE(BAUD),
      .DEPTH   (4)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .wr     (wr),
      .busy   (busy),
      .tx     (tx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic recv_byte(input string tag, output logic [7:0] b,
                            output int ts);
      int n;
      n = 0;
      b = '0;
      while (tx !== 1'b0 && n < 40 * D) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_found"}, {31'd0, tx}, 0);
      ts = cyc;
      wait_neg(D / 2);
      chk({tag, "_startbit"}, {31'd0, tx}, 0);
      for (int i = 0; i < 8; i++) begin
         wait_neg(D);
         b[i] = tx;
      end
      wait_neg(D);
      chk({tag, "_stopbit"}, {31'd0, tx}, 1);
   endtask

   task automatic recv_frame(input string tag, input logic [7:0] e0,
                             input logic [7:0] e1, output int ts);
      logic [7:0] b;
      int t1;
      recv_byte({tag, "_b0"}, b, ts);
      chk({tag, "_byte0"}, {24'd0, b}, {24'd0, e0});
      recv_byte({tag, "_b1"}, b, t1);
      chk({tag, "_byte1"}, {24'd0, b}, {24'd0, e1});
      chk({tag, "_bytegap"}, t1 - ts, 10 * D);
   endtask

   task automatic put(input logic [4:0] a, input logic [7:0] d,
                      output int at);
      wr.wr_valid = 1'b1;
      wr.wr_addr  = a;
      wr.wr_data  = d;
      chk("put_ready", {31'd0, wr.wr_ready}, 1);
      @(negedge clk);
      at = cyc;
      wr.wr_valid = 1'b0;
   endtask

   initial begin
      wr.wr_valid = 1'b0;
      wr.wr_addr  = '0;
      wr.wr_data  = '0;

      // reset
      wait_neg(3);
      chk("rst_tx", {31'd0, tx}, 1);
      chk("rst_ready", {31'd0, wr.wr_ready}, 1);
      chk("rst_busy", {31'd0, busy}, 0);
      reset_n = 1'b1;
      wait_neg(1);
      chk("post_rst_tx", {31'd0, tx}, 1);
      chk("post_rst_ready", {31'd0, wr.wr_ready}, 1);
      chk("post_rst_busy", {31'd0, busy}, 0);
      lows = 0;
      repeat (1000) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      chk("idle_tx_low_cycles", lows, 0);

      // single frame: {3'b100, 5'h15} = 8'h95
      put(5'h15, 8'hA5, acc);
      recv_frame("single", 8'h95, 8'hA5, t0);
      chk("single_latency", t0, acc + 1);
      while (cyc < t0 + 20 * D - 1) @(negedge clk);
      chk("single_busy_last", {31'd0, busy}, 1);
      @(negedge clk);
      chk("single_busy_end", {31'd0, busy}, 0);
      wait_neg(4);

      // backpressure: 6 back-to-back requests, the 6th is refused
      acc = 0;
      fork
         begin
            for (int i = 0; i < 5; i++) begin
               recv_frame($sformatf("bp%0d", i), {3'b100, 5'(i + 1)},
                          8'(8'h40 + i), ts_r);
               if (i == 0) chk("bp_latency", ts_r, acc + 1);
               else chk($sformatf("bp_framegap%0d", i), ts_r - prev_r, 20 * D);
               prev_r = ts_r;
            end
         end
         begin
            for (int i = 0; i < 6; i++) begin
               wr.wr_valid = 1'b1;
               wr.wr_addr  = 5'(i + 1);
               wr.wr_data  = 8'(8'h40 + i);
               chk($sformatf("bp_ready%0d", i), {31'd0, wr.wr_ready},
                   (i < 5) ? 1 : 0);
               @(negedge clk);
               if (i == 0) acc = cyc;
            end
            wr.wr_valid = 1'b0;
            while (cyc < acc + 20 * D) @(negedge clk);
            chk("bp_ready_before_pop2", {31'd0, wr.wr_ready}, 0);
            @(negedge clk);
            chk("bp_ready_after_pop2", {31'd0, wr.wr_ready}, 1);
         end
      join
      wait_neg(D);
      chk("bp_idle", {31'd0, busy}, 0);

      // pointer wrap: 12 frames, valid gated by ready
      wi = 0;
      g  = 0;
      fork
         begin
            for (int i = 0; i < 12; i++) begin
               recv_frame($sformatf("wrap%0d", i), {3'b100, 5'(i + 3)},
                          8'(i * 17 + 1), ts_r);
               if (i > 0)
                  chk($sformatf("wrap_framegap%0d", i), ts_r - prev_r, 20 * D);
               prev_r = ts_r;
            end
         end
         begin
            while (wi < 12 && g < 400 * D) begin
               if (wr.wr_ready) begin
                  wr.wr_valid = 1'b1;
                  wr.wr_addr  = 5'(wi + 3);
                  wr.wr_data  = 8'(wi * 17 + 1);
                  wi++;
               end else begin
                  wr.wr_valid = 1'b0;
               end
               @(negedge clk);
               g++;
            end
            wr.wr_valid = 1'b0;
            chk("wrap_writes", wi, 12);
         end
      join
      wait_neg(D);
      chk("wrap_idle", {31'd0, busy}, 0);

      // push and pop on the same edge with two entries queued
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               recv_frame($sformatf("pp%0d", i), {3'b100, 5'(5'h10 + i)},
                          8'(8'hA0 + i), ts_r);
               if (i > 0)
                  chk($sformatf("pp_framegap%0d", i), ts_r - prev_r, 20 * D);
               prev_r = ts_r;
            end
         end
         begin
            put(5'h10, 8'hA0, acc);
            for (int i = 1; i < 3; i++) begin
               wr.wr_valid = 1'b1;
               wr.wr_addr  = 5'(5'h10 + i);
               wr.wr_data  = 8'(8'hA0 + i);
               chk($sformatf("pp_ready%0d", i), {31'd0, wr.wr_ready}, 1);
               @(negedge clk);
            end
            wr.wr_valid = 1'b0;
            while (cyc < acc + 20 * D) @(negedge clk);
            for (int i = 3; i < 7; i++) begin
               wr.wr_valid = 1'b1;
               wr.wr_addr  = 5'(5'h10 + i);
               wr.wr_data  = 8'(8'hA0 + i);
               chk($sformatf("pp_ready%0d", i), {31'd0, wr.wr_ready},
                   (i < 6) ? 1 : 0);
               @(negedge clk);
            end
            wr.wr_valid = 1'b0;
         end
      join
      wait_neg(D);
      chk("pp_idle", {31'd0, busy}, 0);

      // reset during data bits of byte 0 (8'h80 sends zeros first)
      put(5'h00, 8'h00, acc);
      t0 = acc + 1;
      while (cyc < t0 + 4 * D + 4) @(negedge clk);
      chk("mid_tx_before_rst", {31'd0, tx}, 0);
      #1 reset_n = 1'b0;
      #1;
      chk("mid_rst_tx", {31'd0, tx}, 1);
      chk("mid_rst_busy", {31'd0, busy}, 0);
      chk("mid_rst_ready", {31'd0, wr.wr_ready}, 1);
      wait_neg(3);
      reset_n = 1'b1;
      lows = 0;
      repeat (40 * D) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      chk("after_rst_tx_low_cycles", lows, 0);
      chk("after_rst_busy", {31'd0, busy}, 0);
      put(5'h1F, 8'h3C, acc);
      recv_frame("clean", 8'h9F, 8'h3C, t0);
      chk("clean_latency", t0, acc + 1);
      wait_neg(D);
      chk("clean_idle", {31'd0, busy}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
